// File: rtl/mc_datapath.sv
// rtl/mc_datapath.sv - multi-cycle MIPS-I subset core on a single shared instruction/data memory port
module mc_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc,
    output logic        retire,
    output logic        halted
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [31:0] alu_q, alu_d, mdr_q, mdr_d, target_q, target_d;
    logic [31:0] rf_q [32];
    logic [31:0] rf_d [32];

    logic        req, we, ret;
    logic [31:0] addr, wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext_imm, r_result;
    logic        legal;

    assign op       = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign sext_imm = {{16{ir_q[15]}}, ir_q[15:0]};

    always_comb begin
        legal = 1'b0;
        case (op)
            OP_RTYPE: legal = funct inside {FN_JR, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW: legal = 1'b1;
            default:  legal = 1'b0;
        endcase
    end

    always_comb begin
        r_result = '0;
        case (funct)
            FN_ADD:  r_result = a_q + b_q;
            FN_SUB:  r_result = a_q - b_q;
            FN_AND:  r_result = a_q & b_q;
            FN_OR:   r_result = a_q | b_q;
            FN_SLT:  r_result = {31'b0, $signed(a_q) < $signed(b_q)};
            default: r_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        alu_d    = alu_q;
        mdr_d    = mdr_q;
        target_d = target_q;
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_q;
        req      = 1'b0;
        we       = 1'b0;
        addr     = '0;
        wdata    = '0;
        ret      = 1'b0;
        case (state_q)
            S_FETCH: begin
                req  = 1'b1;
                addr = pc_q;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d      = rf_q[rs];
                b_d      = rf_q[rt];
                target_d = pc_q + {sext_imm[29:0], 2'b00};
                state_d  = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_RTYPE: begin
                        if (funct == FN_JR) begin
                            pc_d = a_q;
                            ret  = 1'b1;
                        end else begin
                            alu_d   = r_result;
                            state_d = S_WB;
                        end
                    end
                    OP_ADDI: begin
                        alu_d   = a_q + sext_imm;
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_d   = a_q + sext_imm;
                        state_d = S_MEM;
                    end
                    OP_BEQ, OP_BNE: begin
                        if ((a_q == b_q) == (op == OP_BEQ)) pc_d = target_q;
                        ret = 1'b1;
                    end
                    OP_J, OP_JAL: begin
                        pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                        ret  = 1'b1;
                        // pc_q already holds the return address (instruction + 4)
                        if (op == OP_JAL) begin
                            rf_we    = 1'b1;
                            rf_waddr = 5'd31;
                            rf_wdata = pc_q;
                        end
                    end
                    default: state_d = S_HALT;
                endcase
            end
            S_MEM: begin
                req   = 1'b1;
                we    = (op == OP_SW);
                addr  = alu_q;
                wdata = b_q;
                if (mem_ready) begin
                    if (op == OP_SW) begin
                        ret     = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                ret     = 1'b1;
                rf_we   = 1'b1;
                state_d = S_FETCH;
                if (op == OP_RTYPE) rf_waddr = rd;
                if (op == OP_LW) rf_wdata = mdr_q;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        rf_d = rf_q;
        if (rf_we && rf_waddr != 5'd0) rf_d[rf_waddr] = rf_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            target_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            alu_q    <= alu_d;
            mdr_q    <= mdr_d;
            target_q <= target_d;
            rf_q     <= rf_d;
        end
    end

    assign mem_req   = req & ~rst;
    assign mem_we    = we & ~rst;
    assign mem_addr  = rst ? 32'd0 : addr;
    assign mem_wdata = rst ? 32'd0 : wdata;
    assign retire    = ret & ~rst;
    assign pc        = pc_q;
    assign halted    = (state_q == S_HALT);
endmodule

// File: tb/tb_mc_datapath.sv
// tb/tb_mc_datapath.sv - directed self-checking bench for mc_datapath
module tb_mc_datapath;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req, mem_we, mem_ready, retire, halted;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

    logic [31:0] mem [256];
    int          wait_n = 0;
    int          wcnt = 0;
    int          st_cnt = 0;
    logic [31:0] st_addr = '0, st_data = '0;

    int          errors = 0;
    int          checks = 0;
    int          kc;
    int          rq[$];
    logic        any_req;

    mc_datapath #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .pc(pc), .retire(retire), .halted(halted)
    );

    always #5 clk = ~clk;

    assign mem_ready = mem_req && (wcnt == wait_n);
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_req && mem_ready) begin
            if (mem_we) begin
                mem[mem_addr[9:2]] = mem_wdata;
                st_addr = mem_addr;
                st_data = mem_wdata;
                st_cnt  = st_cnt + 1;
            end
            wcnt = 0;
        end else if (mem_req) begin
            wcnt = wcnt + 1;
        end else begin
            wcnt = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            kc++;
            if (retire) rq.push_back(kc);
            any_req = any_req | mem_req;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mem_req", {31'b0, mem_req}, 32'd0);
            check("rst_mem_addr", mem_addr, 32'd0);
            @(posedge clk);
        end
        #1 rst = 1'b0;
        kc = -1;
        rq.delete();
        any_req = 1'b0;
    endtask

    initial begin
        // ALU sequence with zero wait states, ending on an illegal opcode
        clear_mem();
        wait_n  = 0;
        mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        mem[65] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
        mem[66] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        mem[67] = enc_r(5'd2, 5'd1, 5'd4, 6'h2A);
        mem[68] = enc_r(5'd2, 5'd1, 5'd5, 6'h22);
        do_reset();
        step(1);
        check("first_req", {31'b0, mem_req}, 32'd1);
        check("first_addr", mem_addr, 32'h100);
        check("first_pc", pc, 32'h100);
        check("first_halted", {31'b0, halted}, 32'd0);
        step(21);
        check("halt_not_yet", {31'b0, halted}, 32'd0);
        any_req = 1'b0;
        step(1);
        check("halt_set", {31'b0, halted}, 32'd1);
        check("halt_pc", pc, 32'h118);
        step(8);
        check("halt_sticky", {31'b0, halted}, 32'd1);
        check("halt_no_req", {31'b0, any_req}, 32'd0);
        check("alu_retire_n", rq.size(), 32'd5);
        for (int i = 0; i < rq.size() && i < 5; i++) check("alu_retire_k", rq[i], 3 + 4 * i);
        check("r1", dut.rf_q[1], 32'd5);
        check("r2", dut.rf_q[2], 32'hFFFF_FFFD);
        check("r3_add", dut.rf_q[3], 32'd2);
        check("r4_slt", dut.rf_q[4], 32'd1);
        check("r5_sub", dut.rf_q[5], 32'hFFFF_FFF8);
        check("r0", dut.rf_q[0], 32'd0);
        do_reset();
        step(1);
        check("rearm_halted", {31'b0, halted}, 32'd0);
        check("rearm_addr", mem_addr, 32'h100);
        check("rearm_req", {31'b0, mem_req}, 32'd1);

        // sw then lw with two wait states on every access
        clear_mem();
        wait_n  = 2;
        st_cnt  = 0;
        mem[64] = enc_i(6'h08, 5'd0, 5'd3, 16'd2);
        mem[65] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
        mem[66] = enc_i(6'h23, 5'd0, 5'd6, 16'd8);
        do_reset();
        step(12);
        check("sw_req", {31'b0, mem_req}, 32'd1);
        check("sw_we", {31'b0, mem_we}, 32'd1);
        check("sw_addr", mem_addr, 32'd8);
        check("sw_wdata", mem_wdata, 32'd2);
        step(3);
        check("sw_fetch_next", {31'b0, mem_req}, 32'd1);
        check("sw_fetch_addr", mem_addr, 32'h108);
        check("sw_fetch_we", {31'b0, mem_we}, 32'd0);
        step(16);
        check("ls_retire_n", rq.size(), 32'd3);
        if (rq.size() == 3) begin
            check("addi_retire", rq[0], 32'd5);
            check("sw_retire", rq[1], 32'd13);
            check("lw_retire", rq[2], 32'd22);
        end
        check("st_cnt", st_cnt, 32'd1);
        check("st_addr", st_addr, 32'd8);
        check("st_data", st_data, 32'd2);
        check("r6_lw", dut.rf_q[6], 32'd2);

        // branches and jumps
        clear_mem();
        wait_n  = 0;
        mem[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd7);
        mem[65] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);
        mem[68] = enc_i(6'h05, 5'd1, 5'd1, 16'd2);
        mem[69] = {6'h03, 26'h000_0050};
        mem[80] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);
        do_reset();
        step(8);
        check("beq_taken_pc", pc, 32'h110);
        step(3);
        check("bne_fall_pc", pc, 32'h114);
        step(3);
        check("jal_pc", pc, 32'h140);
        check("jal_r31", dut.rf_q[31], 32'h118);
        step(3);
        check("jr_pc", pc, 32'h118);
        step(4);
        check("br_halted", {31'b0, halted}, 32'd1);
        check("br_halt_pc", pc, 32'h11C);
        check("br_retire_n", rq.size(), 32'd5);
        for (int i = 0; i < rq.size() && i < 5; i++) check("br_retire_k", rq[i], 3 * (i + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
